// File: rtl/rng_pkg.sv
// rng_pkg: shared types and constants for the RNG bit extractor
package rng_pkg;
    typedef enum logic {MODE_RAW = 1'b0, MODE_VN = 1'b1} mode_e;
    localparam int WORD_W        = 32;
    localparam int BYTE_W        = 8;
    localparam int REP_W         = 6;
    localparam int DEFAULT_DEPTH = 4;
endpackage

// File: rtl/rng_word_fifo.sv
// rng_word_fifo: show-ahead word FIFO whose head holds the last popped word once drained
module rng_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  last;
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign empty   = level == '0;
    assign full    = level == LVL_W'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? last : mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            last  <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) begin
                rp   <= rp + 1'b1;
                last <= mem[rp];
            end
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/rng_bit_extractor.sv
// rng_bit_extractor: folds generator state into bytes, optionally debiases, packs 32-bit words into a FIFO
module rng_bit_extractor
    import rng_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic [WORD_W-1:0] z,
    input  logic              mode,
    input  logic [REP_W-1:0]  rep_limit,
    input  logic              rd_en,
    input  logic              clr_status,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    output logic              rep_fail
);
    logic [BYTE_W-1:0]        r, prev, nb;
    logic [3:0]               vn_bits, n;
    logic [2:0]               vn_cnt;
    mode_e                    cur, mode_q;
    logic                     mode_chg, done, full, empty, ovf_set, rep_set;
    logic [WORD_W-1:0]        acc, base_acc, acc_next, word;
    logic [5:0]               cnt, base_cnt, tot, rem, cnt_next;
    logic [WORD_W+BYTE_W-1:0] comb;
    logic [REP_W-1:0]         run, run_next;
    logic                     unused;
    assign unused   = ^{x[WORD_W-1:BYTE_W], y[WORD_W-1:BYTE_W], z[WORD_W-1:BYTE_W]};
    assign r        = x[BYTE_W-1:0] ^ y[BYTE_W-1:0] ^ z[BYTE_W-1:0];
    assign cur      = mode_e'(mode);
    assign mode_chg = cur != mode_q;
    always_comb begin
        vn_bits = '0;
        vn_cnt  = '0;
        for (int i = 3; i >= 0; i--)
            if (r[2*i+1] != r[2*i]) begin
                vn_bits = {vn_bits[2:0], r[2*i+1]};
                vn_cnt  = vn_cnt + 3'd1;
            end
    end
    // New bits are right-aligned; the accumulator keeps its cnt valid bits right-aligned too.
    assign nb       = cur == MODE_VN ? {4'b0, vn_bits} : r;
    assign n        = cur == MODE_VN ? {1'b0, vn_cnt} : 4'd8;
    assign base_acc = mode_chg ? '0 : acc;
    assign base_cnt = mode_chg ? '0 : cnt;
    assign comb     = ({8'b0, base_acc} << n) | {32'b0, nb};
    assign tot      = base_cnt + {2'b0, n};
    assign done     = sample_valid && tot >= 6'd32;
    assign rem      = tot - 6'd32;
    assign word     = 32'(comb >> rem);
    assign acc_next = done ? 32'(comb & ((40'd1 << rem) - 40'd1)) : comb[WORD_W-1:0];
    assign cnt_next = done ? rem : tot;
    assign run_next = (run != '0 && r == prev) ? (run == '1 ? run : run + 1'b1) : REP_W'(1);
    assign rep_set  = sample_valid && rep_limit != '0 && run_next >= rep_limit;
    assign ovf_set  = done && full && !(rd_en && rd_valid);
    assign rd_valid = !empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            mode_q   <= MODE_RAW;
            prev     <= '0;
            run      <= '0;
            overflow <= 1'b0;
            rep_fail <= 1'b0;
        end else begin
            if (sample_valid) begin
                acc    <= acc_next;
                cnt    <= cnt_next;
                mode_q <= cur;
                prev   <= r;
                run    <= run_next;
            end
            overflow <= ovf_set | (overflow & ~clr_status);
            rep_fail <= rep_set | (rep_fail & ~clr_status);
        end
    end
    rng_word_fifo #(.DEPTH(DEPTH), .W(WORD_W), .LVL_W(LVL_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (done),
        .pop   (rd_en),
        .din   (word),
        .head  (rd_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );
endmodule

// File: tb/tb_rng_bit_extractor.sv
// tb_rng_bit_extractor: directed self-checking bench for rng_bit_extractor
module tb_rng_bit_extractor;
    logic        clk = 0, rst_n = 1, sample_valid = 0, mode = 0, rd_en = 0, clr_status = 0;
    logic [31:0] x = 0, y = 0, z = 0;
    logic [5:0]  rep_limit = 0;
    logic [31:0] rd_data;
    logic        rd_valid, overflow, rep_fail;
    logic [2:0]  fifo_level;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    rng_bit_extractor #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .x            (x),
        .y            (y),
        .z            (z),
        .mode         (mode),
        .rep_limit    (rep_limit),
        .rd_en        (rd_en),
        .clr_status   (clr_status),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .rep_fail     (rep_fail)
    );

    // Called at a falling edge; returns at the next falling edge. Low bytes of y,z cancel.
    task automatic samp(input logic [7:0] r, input logic m);
        x = {24'hA5A5A5, r ^ 8'h3C};
        y = {24'h5A5A5A, 8'h69};
        z = {24'h123456, 8'h55};
        mode = m;
        sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
    endtask

    task automatic pop();
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
    endtask

    task automatic clr();
        clr_status = 1;
        @(negedge clk);
        clr_status = 0;
    endtask

    task automatic test_reset(input string nm);
        n_vec++;
        if ({rd_data, rd_valid, fifo_level, overflow, rep_fail} !== 38'd0) begin
            n_err++;
            $display("FAIL %s: data=%h valid=%b level=%0d ovf=%b rep=%b, want all 0",
                     nm, rd_data, rd_valid, fifo_level, overflow, rep_fail);
        end
    endtask

    task automatic test_raw();
        samp(8'h11, 0); samp(8'h22, 0); samp(8'h33, 0);
        n_vec++;
        if (rd_valid !== 1'b0) begin n_err++; $display("FAIL raw_early_valid: got %b want 0", rd_valid); end
        samp(8'h44, 0);
        n_vec++;
        if (rd_valid !== 1'b1) begin n_err++; $display("FAIL raw_valid: got %b want 1", rd_valid); end
        n_vec++;
        if (fifo_level !== 3'd1) begin n_err++; $display("FAIL raw_level: got %0d want 1", fifo_level); end
        n_vec++;
        if (rd_data !== 32'h11223344) begin n_err++; $display("FAIL raw_word: got %h want 11223344", rd_data); end
        pop();
        n_vec++;
        if (rd_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_err++; $display("FAIL raw_pop: valid=%b level=%0d want 0/0", rd_valid, fifo_level);
        end
        n_vec++;
        if (rd_data !== 32'h11223344) begin n_err++; $display("FAIL raw_hold: got %h want 11223344", rd_data); end
    endtask

    task automatic test_vn();
        repeat (15) samp(8'h93, 1);
        n_vec++;
        if (rd_valid !== 1'b0) begin n_err++; $display("FAIL vn_15: valid got %b want 0", rd_valid); end
        samp(8'h93, 1);
        n_vec++;
        if (rd_data !== 32'hAAAAAAAA) begin n_err++; $display("FAIL vn_word: got %h want aaaaaaaa", rd_data); end
        n_vec++;
        if (fifo_level !== 3'd1) begin n_err++; $display("FAIL vn_level: got %0d want 1", fifo_level); end
        pop();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w [4];
        exp_w = '{32'h090A0B0C, 32'h0D0E0F10, 32'h15161718, 32'h15161718};
        for (int i = 0; i < 20; i++) samp(8'(i + 1), 0);
        n_vec++;
        if (fifo_level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        n_vec++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_vec++;
        if (rd_data !== 32'h01020304) begin n_err++; $display("FAIL ovf_head: got %h want 01020304", rd_data); end
        clr();
        n_vec++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        samp(8'h15, 0); samp(8'h16, 0); samp(8'h17, 0);
        rd_en = 1;
        samp(8'h18, 0);
        rd_en = 0;
        n_vec++;
        if (fifo_level !== 3'd4) begin n_err++; $display("FAIL pushpop_level: got %0d want 4", fifo_level); end
        n_vec++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL pushpop_ovf: got %b want 0", overflow); end
        n_vec++;
        if (rd_data !== 32'h05060708) begin n_err++; $display("FAIL pushpop_head: got %h want 05060708", rd_data); end
        for (int i = 0; i < 4; i++) begin
            pop();
            n_vec++;
            if (rd_data !== exp_w[i]) begin n_err++; $display("FAIL drain_%0d: got %h want %h", i, rd_data, exp_w[i]); end
        end
        pop();
        n_vec++;
        if (fifo_level !== 3'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL pop_empty: level=%0d valid=%b ovf=%b want 0/0/0", fifo_level, rd_valid, overflow);
        end
    endtask

    task automatic test_rep();
        rep_limit = 3;
        samp(8'h5A, 0); samp(8'h5A, 0); samp(8'hC3, 0); samp(8'hC3, 0);
        n_vec++;
        if (rep_fail !== 1'b0) begin n_err++; $display("FAIL rep_early: got %b want 0", rep_fail); end
        samp(8'hC3, 0);
        n_vec++;
        if (rep_fail !== 1'b1) begin n_err++; $display("FAIL rep_trip: got %b want 1", rep_fail); end
        clr();
        n_vec++;
        if (rep_fail !== 1'b0) begin n_err++; $display("FAIL rep_clear: got %b want 0", rep_fail); end
        rep_limit = 0;
        repeat (70) samp(8'h77, 0);
        n_vec++;
        if (rep_fail !== 1'b0) begin n_err++; $display("FAIL rep_disabled: got %b want 0", rep_fail); end
        rep_limit = 63;
        clr_status = 1;
        samp(8'h77, 0);
        clr_status = 0;
        n_vec++;
        if (rep_fail !== 1'b1) begin n_err++; $display("FAIL rep_sat_set_wins: got %b want 1", rep_fail); end
        rep_limit = 0;
        clr();
        n_vec++;
        if (rep_fail !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL status_clear: rep=%b ovf=%b want 0/0", rep_fail, overflow);
        end
    endtask

    task automatic test_mode_switch();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        samp(8'hFF, 0); samp(8'h00, 0);
        repeat (15) samp(8'h93, 1);
        n_vec++;
        if (rd_valid !== 1'b0) begin n_err++; $display("FAIL switch_early: valid got %b want 0", rd_valid); end
        samp(8'h93, 1);
        n_vec++;
        if (rd_data !== 32'hAAAAAAAA || fifo_level !== 3'd1) begin
            n_err++; $display("FAIL switch_word: got %h level %0d want aaaaaaaa level 1", rd_data, fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        samp(8'h01, 0); samp(8'h02, 0); samp(8'h03, 0); samp(8'h04, 0);
        n_vec++;
        if (fifo_level !== 3'd2) begin n_err++; $display("FAIL mid_level: got %0d want 2", fifo_level); end
        rep_limit = 2;
        samp(8'hAB, 0); samp(8'hAB, 0);
        n_vec++;
        if (rep_fail !== 1'b1) begin n_err++; $display("FAIL mid_rep: got %b want 1", rep_fail); end
        #2 rst_n = 0;
        #1 test_reset("reset_async");
        @(negedge clk);
        rst_n = 1;
        rep_limit = 0;
        samp(8'hDE, 0); samp(8'hAD, 0); samp(8'hBE, 0);
        n_vec++;
        if (rd_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_early: valid got %b want 0", rd_valid); end
        samp(8'hEF, 0);
        n_vec++;
        if (rd_data !== 32'hDEADBEEF || fifo_level !== 3'd1) begin
            n_err++; $display("FAIL post_reset_word: got %h level %0d want deadbeef level 1", rd_data, fifo_level);
        end
    endtask

    initial begin
        #1 rst_n = 0;
        #1 test_reset("reset");
        @(negedge clk);
        rst_n = 1;
        test_raw();
        test_vn();
        test_overflow();
        test_rep();
        test_mode_switch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
